// File: rtl/bcd_date_counter.sv
// BCD calendar date counter (DD/MM/YY) advanced by day_tick, with a validated
// date load and a one-cycle century wrap flag on 99 -> 00.
module bcd_date_counter #(
    parameter logic [7:0] RESET_DAY   = 8'h01,
    parameter logic [7:0] RESET_MONTH = 8'h01,
    parameter logic [7:0] RESET_YEAR  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       day_tick,
    input  logic       leap_year,
    input  logic       set_valid,
    input  logic [7:0] set_day,
    input  logic [7:0] set_month,
    input  logic [7:0] set_year,
    output logic [7:0] day_bcd,
    output logic [7:0] month_bcd,
    output logic [7:0] year_bcd,
    output logic       set_ack,
    output logic       set_err,
    output logic       century_wrap
);

    logic [7:0] day_q, day_d;
    logic [7:0] month_q, month_d;
    logic [7:0] year_q, year_d;
    logic       set_ack_q, set_ack_d;
    logic       set_err_q, set_err_d;
    logic       wrap_q, wrap_d;
    logic       set_ok;

    // Two-digit BCD increment; callers handle any wrap beyond 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'h1};
        end
        return r;
    endfunction

    // Last day of a BCD month; 00 for a non-existent month so any day fails.
    function automatic logic [7:0] last_day(input logic [7:0] m, input logic leap);
        logic [7:0] r;
        case (m)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: r = 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      r = 8'h30;
            8'h02:   r = leap ? 8'h29 : 8'h28;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Divisible-by-4 test on a BCD year: tens parity selects the units set.
    function automatic logic year_div4(input logic [7:0] y);
        logic r;
        if (y[4]) begin
            r = (y[3:0] == 4'h2) || (y[3:0] == 4'h6);
        end else begin
            r = (y[3:0] == 4'h0) || (y[3:0] == 4'h4) || (y[3:0] == 4'h8);
        end
        return r;
    endfunction

    function automatic logic nibbles_ok(input logic [7:0] v);
        return (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9);
    endfunction

    always_comb begin
        set_ok = nibbles_ok(set_day) && nibbles_ok(set_month) && nibbles_ok(set_year)
              && (set_month >= 8'h01) && (set_month <= 8'h12)
              && (set_day >= 8'h01)
              && (set_day <= last_day(set_month, year_div4(set_year)));
    end

    // Next-state: a load takes priority over a tick in the same cycle.
    always_comb begin
        day_d     = day_q;
        month_d   = month_q;
        year_d    = year_q;
        set_ack_d = 1'b0;
        set_err_d = 1'b0;
        wrap_d    = 1'b0;
        if (set_valid) begin
            if (set_ok) begin
                day_d     = set_day;
                month_d   = set_month;
                year_d    = set_year;
                set_ack_d = 1'b1;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (day_tick) begin
            if (day_q >= last_day(month_q, leap_year)) begin
                day_d = 8'h01;
                if (month_q == 8'h12) begin
                    month_d = 8'h01;
                    if (year_q == 8'h99) begin
                        year_d = 8'h00;
                        wrap_d = 1'b1;
                    end else begin
                        year_d = bcd_inc(year_q);
                    end
                end else begin
                    month_d = bcd_inc(month_q);
                end
            end else begin
                day_d = bcd_inc(day_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            day_q     <= RESET_DAY;
            month_q   <= RESET_MONTH;
            year_q    <= RESET_YEAR;
            set_ack_q <= 1'b0;
            set_err_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            day_q     <= day_d;
            month_q   <= month_d;
            year_q    <= year_d;
            set_ack_q <= set_ack_d;
            set_err_q <= set_err_d;
            wrap_q    <= wrap_d;
        end
    end

    assign day_bcd      = day_q;
    assign month_bcd    = month_q;
    assign year_bcd     = year_q;
    assign set_ack      = set_ack_q;
    assign set_err      = set_err_q;
    assign century_wrap = wrap_q;

endmodule
